// File: rtl/disp_scan_driver_pkg.sv
// Shared constants for the multiplexed six-digit clock display driver:
// digit count and active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package disp_scan_driver_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/disp_scan_driver_if.sv
// Display driver bus: time digits and set-mode controls in, scan outputs out.
// master = the block feeding time data, slave = the scan driver itself.
interface disp_scan_driver_if;
    logic [23:0] digits;
    logic        set_time;
    logic [1:0]  slt_idx;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output digits, set_time, slt_idx,
        input  an, seg, dp
    );

    modport slave (
        input  digits, set_time, slt_idx,
        output an, seg, dp
    );
endinterface

// File: rtl/disp_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal
// nibbles render as a dash.
module bcd_to_seg7
    import disp_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_scan_driver.sv
// Time-multiplexed six-digit display scanner with leading-zero blanking and
// set-mode field blinking; all timing derived from clock-enable ticks.
module disp_scan_driver
    import disp_scan_driver_pkg::*;
#(
    parameter int DWELL        = 50000,
    parameter int BLINK_FRAMES = 64
)
(
    input  logic                 clkmain,
    input  logic                 clear,
    disp_scan_driver_if.slave    bus
);

    localparam int DW = $clog2(DWELL);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam digit_idx_t    IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [DW-1:0] dwell_reg, dwell_next;
    digit_idx_t    idx_reg, idx_next;
    logic [FW-1:0] frame_reg, frame_next;
    logic          blink_phase_reg, blink_phase_next;
    logic [23:0]   shadow_reg, shadow_next;
    logic          first_reg;
    logic [5:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;

    logic          slot_tick, frame_tick;
    logic [5:0]    an_lit;
    logic [3:0]    nib_arr [0:7];
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic          lz_blank, blink_blank, slot_blank;

    assign slot_tick  = (dwell_reg == DWELL_LAST);
    assign frame_tick = slot_tick && (idx_reg == IDX_LAST);

    // Nibble mux padded to eight entries so any 3-bit index is in range.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            if (gi < NUM_DIGITS) begin : g_real
                assign nib_arr[gi] = shadow_reg[gi*4 +: 4];
            end else begin : g_pad
                assign nib_arr[gi] = 4'hF;
            end
        end
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
            assign an_lit[gi] = (idx_reg != 3'(gi));
        end
    endgenerate

    assign nibble = nib_arr[idx_reg];

    bcd_to_seg7 u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    always_comb begin
        dwell_next       = dwell_reg + 1'b1;
        idx_next         = idx_reg;
        frame_next       = frame_reg;
        blink_phase_next = blink_phase_reg;
        shadow_next      = shadow_reg;
        if (slot_tick) begin
            dwell_next = '0;
            idx_next   = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
        end
        if (frame_tick) begin
            if (frame_reg == FRAME_LAST) begin
                frame_next       = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_next = frame_reg + 1'b1;
            end
        end
        if (first_reg || frame_tick) begin
            shadow_next = bus.digits;
        end
    end

    assign lz_blank    = (idx_reg == IDX_LAST) && (shadow_reg[23:20] == 4'd0);
    assign blink_blank = bus.set_time && blink_phase_reg && (bus.slt_idx != 2'd3)
                         && (idx_reg[2:1] == bus.slt_idx);
    assign slot_blank  = lz_blank || blink_blank;

    // Outputs stay dark during the capture cycle so the first lit slot
    // always shows freshly captured data.
    always_comb begin
        an_next  = an_lit;
        seg_next = dec_seg;
        dp_next  = !((idx_reg == 3'd2) || (idx_reg == 3'd4));
        if (slot_blank || first_reg) begin
            an_next  = 6'h3F;
            seg_next = SEG_BLANK;
            dp_next  = 1'b1;
        end
    end

    always_ff @(posedge clkmain) begin
        if (clear) begin
            dwell_reg       <= '0;
            idx_reg         <= '0;
            frame_reg       <= '0;
            blink_phase_reg <= 1'b0;
            shadow_reg      <= '0;
            first_reg       <= 1'b1;
            an_reg          <= 6'h3F;
            seg_reg         <= SEG_BLANK;
            dp_reg          <= 1'b1;
        end else begin
            dwell_reg       <= dwell_next;
            idx_reg         <= idx_next;
            frame_reg       <= frame_next;
            blink_phase_reg <= blink_phase_next;
            shadow_reg      <= shadow_next;
            first_reg       <= 1'b0;
            an_reg          <= an_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
        end
    end

    assign bus.an  = an_reg;
    assign bus.seg = seg_reg;
    assign bus.dp  = dp_reg;

endmodule
